// File: rtl/stim_seq_gen.sv
// Boot/interrupt stimulus sequencer: delayed cpu_start pulse followed by NCH staggered irq trains.
// Raises a sticky done once every enabled train has finished and one trailing PERIOD has elapsed.
module stim_seq_gen #(
    parameter int unsigned NCH       = 4,
    parameter int unsigned CNT_W     = 24,
    parameter int unsigned START_DLY = 100,
    parameter logic [29:0] START_ADR = 30'h0,
    parameter int unsigned PERIOD    = 100000,
    parameter int unsigned PULSE_W   = 1000,
    parameter int unsigned NPULSE    = 3,
    parameter int unsigned STAGGER   = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] ch_en,
    input  logic           hold,
    output logic           cpu_start,
    output logic [29:0]    cpu_start_adr,
    output logic [NCH-1:0] irq,
    output logic           busy,
    output logic           done
);

    localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;
    localparam logic [CNT_W-1:0] DLY_C   = CNT_W'(START_DLY);
    localparam logic [CNT_W-1:0] PER_C   = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0] PW_C    = CNT_W'(PULSE_W);
    localparam logic [CNT_W-1:0] NP_LAST = CNT_W'(NPULSE - 1);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    if (NCH < 1 || NCH > 8) begin : g_bad_nch
        $error("stim_seq_gen: NCH must be in 1..8");
    end
    if (PERIOD == 0 || PULSE_W == 0) begin : g_bad_zero
        $error("stim_seq_gen: PERIOD and PULSE_W must be >= 1");
    end
    if (64'(PERIOD) > CNT_MAX || 64'(PULSE_W) > CNT_MAX || 64'(START_DLY) > CNT_MAX ||
        64'(STAGGER) * 64'(NCH - 1) > CNT_MAX) begin : g_bad_width
        $error("stim_seq_gen: timing parameter does not fit in CNT_W");
    end

    typedef enum logic [2:0] {S_BOOT, S_START, S_RUN, S_TAIL, S_DONE} state_t;
    typedef enum logic [2:0] {C_IDLE, C_STAG, C_GAP, C_HIGH, C_FIN} ch_ph_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    ch_ph_t           ph [NCH];
    ch_ph_t           ph_nxt [NCH];
    logic [CNT_W-1:0] ccnt [NCH];
    logic [CNT_W-1:0] ccnt_nxt [NCH];
    logic [CNT_W-1:0] np [NCH];
    logic [CNT_W-1:0] np_nxt [NCH];
    logic             all_fin;
    logic             cpu_start_nxt;
    logic [29:0]      cpu_start_adr_nxt;
    logic [NCH-1:0]   irq_nxt;
    logic             busy_nxt;
    logic             done_nxt;

    // Next-state, per-channel engines and registered-output precompute
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ph_nxt    = ph;
        ccnt_nxt  = ccnt;
        np_nxt    = np;
        all_fin   = 1'b1;

        if (state == S_RUN) begin
            for (int k = 0; k < NCH; k++) begin
                case (ph[k])
                    C_STAG: begin
                        if (ccnt[k] == CNT_W'(k * STAGGER)) begin
                            ph_nxt[k]   = C_GAP;
                            ccnt_nxt[k] = ONE_C;
                        end else begin
                            ccnt_nxt[k] = ccnt[k] + ONE_C;
                        end
                    end
                    C_GAP: begin
                        if (ccnt[k] == PER_C) begin
                            ph_nxt[k]   = C_HIGH;
                            ccnt_nxt[k] = ONE_C;
                        end else begin
                            ccnt_nxt[k] = ccnt[k] + ONE_C;
                        end
                    end
                    C_HIGH: begin
                        if (ccnt[k] == PW_C) begin
                            np_nxt[k]   = np[k] + ONE_C;
                            ccnt_nxt[k] = ONE_C;
                            // NPULSE=0 never finishes: trains repeat forever
                            if (NPULSE != 0 && np[k] == NP_LAST) begin
                                ph_nxt[k] = C_FIN;
                            end else begin
                                ph_nxt[k] = C_GAP;
                            end
                        end else begin
                            ccnt_nxt[k] = ccnt[k] + ONE_C;
                        end
                    end
                    default: ;
                endcase
            end
        end

        for (int k = 0; k < NCH; k++) begin
            if (ph_nxt[k] inside {C_STAG, C_GAP, C_HIGH}) begin
                all_fin = 1'b0;
            end
        end

        case (state)
            S_BOOT: begin
                if (cnt == DLY_C) begin
                    state_nxt = S_START;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + ONE_C;
                end
            end
            S_START: begin
                // ch_en is sampled only here; later changes are ignored
                for (int k = 0; k < NCH; k++) begin
                    if (ch_en[k]) begin
                        ph_nxt[k]   = (k * STAGGER == 0) ? C_GAP : C_STAG;
                        ccnt_nxt[k] = ONE_C;
                        np_nxt[k]   = '0;
                    end
                end
                state_nxt = (|ch_en) ? S_RUN : S_TAIL;
                cnt_nxt   = ONE_C;
            end
            S_RUN: begin
                if (all_fin) begin
                    state_nxt = S_TAIL;
                    cnt_nxt   = ONE_C;
                end
            end
            S_TAIL: begin
                if (cnt == PER_C) begin
                    state_nxt = S_DONE;
                end else begin
                    cnt_nxt = cnt + ONE_C;
                end
            end
            default: state_nxt = S_DONE;
        endcase

        cpu_start_nxt     = (state_nxt == S_START);
        cpu_start_adr_nxt = cpu_start_nxt ? START_ADR : 30'h0;
        for (int k = 0; k < NCH; k++) begin
            irq_nxt[k] = (ph_nxt[k] == C_HIGH);
        end
        busy_nxt = (state_nxt != S_DONE);
        done_nxt = (state_nxt == S_DONE);
    end

    // State and output registers; hold freezes everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_BOOT;
            cnt           <= '0;
            for (int k = 0; k < NCH; k++) begin
                ph[k]   <= C_IDLE;
                ccnt[k] <= '0;
                np[k]   <= '0;
            end
            cpu_start     <= 1'b0;
            cpu_start_adr <= 30'h0;
            irq           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else if (!hold) begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            ph            <= ph_nxt;
            ccnt          <= ccnt_nxt;
            np            <= np_nxt;
            cpu_start     <= cpu_start_nxt;
            cpu_start_adr <= cpu_start_adr_nxt;
            irq           <= irq_nxt;
            busy          <= busy_nxt;
            done          <= done_nxt;
        end
    end

endmodule

// File: tb/tb_stim_seq_gen.sv
// Directed bench for stim_seq_gen: vector table for the basic sequence plus hand-written
// sequences for stagger, no-channel, hold, mid-run reset and continuous mode.
module tb_stim_seq_gen;

    localparam logic [29:0] ADR_A = 30'h1234567;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hold = 1'b0;
    logic [3:0]  en_a = 4'b0, en_b = 4'b0, en_c = 4'b0;
    logic        cs_a, cs_b, cs_c;
    logic [29:0] adr_a, adr_b, adr_c;
    logic [3:0]  irq_a, irq_b, irq_c;
    logic        busy_a, busy_b, busy_c;
    logic        done_a, done_b, done_c;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    stim_seq_gen #(.NCH(4), .CNT_W(24), .START_DLY(5), .START_ADR(ADR_A), .PERIOD(10),
                   .PULSE_W(2), .NPULSE(3), .STAGGER(0)) u_a (
        .clk(clk), .rst(rst), .ch_en(en_a), .hold(hold), .cpu_start(cs_a),
        .cpu_start_adr(adr_a), .irq(irq_a), .busy(busy_a), .done(done_a));

    stim_seq_gen #(.NCH(4), .CNT_W(24), .START_DLY(5), .START_ADR(30'h0), .PERIOD(10),
                   .PULSE_W(2), .NPULSE(3), .STAGGER(3)) u_b (
        .clk(clk), .rst(rst), .ch_en(en_b), .hold(1'b0), .cpu_start(cs_b),
        .cpu_start_adr(adr_b), .irq(irq_b), .busy(busy_b), .done(done_b));

    stim_seq_gen #(.NCH(4), .CNT_W(24), .START_DLY(5), .START_ADR(30'h0), .PERIOD(10),
                   .PULSE_W(2), .NPULSE(0), .STAGGER(0)) u_c (
        .clk(clk), .rst(rst), .ch_en(en_c), .hold(1'b0), .cpu_start(cs_c),
        .cpu_start_adr(adr_c), .irq(irq_c), .busy(busy_c), .done(done_c));

    typedef struct {
        int         cyc;
        logic [3:0] irq;
        logic       cs;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t vt [18];

    task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, exp);
        end
    endtask

    // Reset all instances; the next posedge after release is cycle 0
    task automatic do_reset();
        rst  = 1'b1;
        hold = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Instance A sweep: irq[0] expected high in up to three [a,b] windows
    task automatic sweep_a(input string tag, input logic [3:0] en, input int hold_from, input int hold_to,
                           input int cs_lo, input int cs_hi, input int a0, input int b0,
                           input int a1, input int b1, input int a2, input int b2,
                           input int done_at, input int ncyc, input int rst_at);
        logic [3:0] e_irq;
        logic       e_cs;
        en_a = en;
        do_reset();
        for (int c = 0; c <= ncyc; c++) begin
            @(negedge clk);
            e_irq = ((c >= a0 && c <= b0) || (c >= a1 && c <= b1) || (c >= a2 && c <= b2)) ? 4'b0001 : 4'b0000;
            e_cs  = (c >= cs_lo && c <= cs_hi);
            chk({tag, ".irq"}, c, 32'(irq_a), 32'(e_irq));
            chk({tag, ".cpu_start"}, c, 32'(cs_a), 32'(e_cs));
            chk({tag, ".adr"}, c, 32'(adr_a), e_cs ? 32'(ADR_A) : 32'h0);
            chk({tag, ".done"}, c, 32'(done_a), 32'(c >= done_at));
            chk({tag, ".busy"}, c, 32'(busy_a), 32'(c < done_at));
            hold = (c >= hold_from && c <= hold_to);
            if (c == rst_at) begin
                rst = 1'b1;
                #1;
                chk({tag, ".rst_irq"}, c, 32'(irq_a), 32'h0);
                chk({tag, ".rst_cs"}, c, 32'(cs_a), 32'h0);
                chk({tag, ".rst_done"}, c, 32'(done_a), 32'h0);
                chk({tag, ".rst_busy"}, c, 32'(busy_a), 32'h0);
                return;
            end
        end
        hold = 1'b0;
    endtask

    initial begin
        int         vi;
        logic [3:0] e_irq;
        int         s;
        int         rises;
        logic       prev;

        // Case 1 vector table: {cycle, irq, cpu_start, busy, done}
        vt[0]  = '{0,  4'b0000, 1'b0, 1'b1, 1'b0};
        vt[1]  = '{4,  4'b0000, 1'b0, 1'b1, 1'b0};
        vt[2]  = '{5,  4'b0000, 1'b1, 1'b1, 1'b0};
        vt[3]  = '{6,  4'b0000, 1'b0, 1'b1, 1'b0};
        vt[4]  = '{15, 4'b0000, 1'b0, 1'b1, 1'b0};
        vt[5]  = '{16, 4'b0001, 1'b0, 1'b1, 1'b0};
        vt[6]  = '{17, 4'b0001, 1'b0, 1'b1, 1'b0};
        vt[7]  = '{18, 4'b0000, 1'b0, 1'b1, 1'b0};
        vt[8]  = '{27, 4'b0000, 1'b0, 1'b1, 1'b0};
        vt[9]  = '{28, 4'b0001, 1'b0, 1'b1, 1'b0};
        vt[10] = '{29, 4'b0001, 1'b0, 1'b1, 1'b0};
        vt[11] = '{30, 4'b0000, 1'b0, 1'b1, 1'b0};
        vt[12] = '{40, 4'b0001, 1'b0, 1'b1, 1'b0};
        vt[13] = '{41, 4'b0001, 1'b0, 1'b1, 1'b0};
        vt[14] = '{42, 4'b0000, 1'b0, 1'b1, 1'b0};
        vt[15] = '{51, 4'b0000, 1'b0, 1'b1, 1'b0};
        vt[16] = '{52, 4'b0000, 1'b0, 1'b0, 1'b1};
        vt[17] = '{60, 4'b0000, 1'b0, 1'b0, 1'b1};

        // Reset state before any release
        @(negedge clk);
        chk("reset.irq", -1, 32'(irq_a), 32'h0);
        chk("reset.cpu_start", -1, 32'(cs_a), 32'h0);
        chk("reset.busy", -1, 32'(busy_a), 32'h0);
        chk("reset.done", -1, 32'(done_a), 32'h0);

        // Case 1: single channel via table
        en_a = 4'b0001;
        do_reset();
        vi = 0;
        for (int c = 0; c <= 60; c++) begin
            @(negedge clk);
            if (vi < 18) begin
                if (vt[vi].cyc == c) begin
                    chk("t1.irq", c, 32'(irq_a), 32'(vt[vi].irq));
                    chk("t1.cpu_start", c, 32'(cs_a), 32'(vt[vi].cs));
                    chk("t1.adr", c, 32'(adr_a), vt[vi].cs ? 32'(ADR_A) : 32'h0);
                    chk("t1.busy", c, 32'(busy_a), 32'(vt[vi].busy));
                    chk("t1.done", c, 32'(done_a), 32'(vt[vi].done));
                    vi++;
                end
            end
        end
        chk("t1.vectors_applied", 60, 32'(vi), 32'd18);

        // Case 2: four channels staggered by 3
        en_b = 4'b1111;
        do_reset();
        for (int c = 0; c <= 65; c++) begin
            @(negedge clk);
            e_irq = 4'b0;
            for (int k = 0; k < 4; k++) begin
                for (int j = 0; j < 3; j++) begin
                    s = 6 + 3 * k + (j + 1) * 10 + j * 2;
                    if (c >= s && c <= s + 1) e_irq[k] = 1'b1;
                end
            end
            chk("t2.irq", c, 32'(irq_b), 32'(e_irq));
            chk("t2.cpu_start", c, 32'(cs_b), 32'(c == 5));
            chk("t2.adr", c, 32'(adr_b), 32'h0);
            chk("t2.done", c, 32'(done_b), 32'(c >= 61));
            chk("t2.busy", c, 32'(busy_b), 32'(c < 61));
        end

        // Case 3: no channel enabled
        sweep_a("t3", 4'b0000, -1, -1, 5, 5, -1, -1, -1, -1, -1, -1, 16, 25, -1);

        // Case 4: hold during first pulse stretches it and shifts the rest by 5
        sweep_a("t4", 4'b0001, 16, 20, 5, 5, 16, 22, 33, 34, 45, 46, 57, 62, -1);

        // Hold over the cpu_start cycle repeats it
        sweep_a("t4s", 4'b0001, 5, 6, 5, 7, 18, 19, 30, 31, 42, 43, 54, 58, -1);

        // Case 5: reset in cycle 29 then full replay
        sweep_a("t5a", 4'b0001, -1, -1, 5, 5, 16, 17, 28, 29, 40, 41, 52, 40, 29);
        sweep_a("t5b", 4'b0001, -1, -1, 5, 5, 16, 17, 28, 29, 40, 41, 52, 56, -1);

        // Case 6: continuous mode, period 12 indefinitely
        en_c = 4'b0001;
        do_reset();
        rises = 0;
        prev  = 1'b0;
        for (int c = 0; c <= 1250; c++) begin
            @(negedge clk);
            e_irq = (c >= 16 && ((c - 16) % 12) < 2) ? 4'b0001 : 4'b0000;
            chk("t6.irq", c, 32'(irq_c), 32'(e_irq));
            chk("t6.cpu_start", c, 32'(cs_c), 32'(c == 5));
            chk("t6.adr", c, 32'(adr_c), 32'h0);
            chk("t6.done", c, 32'(done_c), 32'h0);
            chk("t6.busy", c, 32'(busy_c), 32'h1);
            if (irq_c[0] && !prev) rises++;
            prev = irq_c[0];
        end
        chk("t6.pulse_count_ge_100", 1250, 32'(rises >= 100), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
